// File: rtl/shift_disp_pkg.sv
// shift_disp_pkg: shared state encoding, seven-segment glyphs and BCD helper for the display driver
package shift_disp_pkg;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  localparam int NUM_DIGITS = 6;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;
  localparam logic [7:0] SEG_LUT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                          SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  function automatic logic [3:0] dabble(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-low seven-segment glyph, dp off, with blanking
module seg7_decode
  import shift_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] seg_n
);
  assign seg_n = blank ? SEG_BLANK : SEG_LUT[nibble];
endmodule

// File: rtl/shift_disp_driver.sv
// shift_disp_driver: shows an 8-bit value as hex and unsigned decimal on a six-digit multiplexed display
module shift_disp_driver
  import shift_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data_in,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  busy
);
  localparam int SW = $clog2(SCAN_DIV);
  state_t        state;
  logic [7:0]    last_val, sh, disp_bin, seg_next;
  logic [11:0]   bcd, bcd_adj, disp_bcd;
  logic [2:0]    bit_cnt, dig_idx;
  logic [SW-1:0] scan_cnt;
  logic [3:0]    nib;
  logic          blank;
  assign busy = state != IDLE;
  assign bcd_adj = {dabble(bcd[11:8]), dabble(bcd[7:4]), dabble(bcd[3:0])};
  // accept a changed input, run eight adjust-and-shift steps, then publish hex and decimal together
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      last_val <= '0;
      sh <= '0;
      bcd <= '0;
      bit_cnt <= '0;
      disp_bin <= '0;
      disp_bcd <= '0;
    end else
      case (state)
        IDLE: if (data_in != last_val) begin
          sh <= data_in;
          last_val <= data_in;
          bcd <= '0;
          bit_cnt <= '0;
          state <= CONV;
        end
        CONV: begin
          {bcd, sh} <= {bcd_adj, sh} << 1;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= LOAD;
        end
        LOAD: begin
          disp_bin <= last_val;
          disp_bcd <= bcd;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  // each digit is enabled for exactly SCAN_DIV cycles, wrapping 5 to 0 with no gap
  always_ff @(posedge clk)
    if (rst) begin
      scan_cnt <= '0;
      dig_idx <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx <= dig_idx == 3'(NUM_DIGITS - 1) ? 3'd0 : dig_idx + 3'd1;
    end else
      scan_cnt <= scan_cnt + SW'(1);
  // pick the nibble for the active digit; leading decimal zeros and the spacer digit are blanked
  always_comb begin
    nib = dig_idx == 3'd0 ? disp_bin[3:0] :
          dig_idx == 3'd1 ? disp_bin[7:4] :
          dig_idx == 3'd3 ? disp_bcd[3:0] :
          dig_idx == 3'd4 ? disp_bcd[7:4] : disp_bcd[11:8];
    blank = dig_idx == 3'd2 ||
            (dig_idx == 3'd4 && disp_bcd[11:4] == 8'd0) ||
            (dig_idx == 3'd5 && disp_bcd[11:8] == 4'd0);
  end
  seg7_decode u_dec (
    .nibble(nib),
    .blank (blank),
    .seg_n (seg_next)
  );
  // register segment and anode drives so they change together, glitch-free
  always_ff @(posedge clk)
    if (rst) begin
      seg_n <= SEG_BLANK;
      an_n <= ~NUM_DIGITS'(1);
    end else begin
      seg_n <= seg_next;
      an_n <= ~(NUM_DIGITS'(1) << dig_idx);
    end
endmodule

// File: tb/tb_shift_disp_driver.sv
// tb_shift_disp_driver: scoreboard bench for the hex/decimal display driver
module tb_shift_disp_driver;
  typedef struct packed {
    logic [7:0]  bin;
    logic [11:0] bcd;
  } exp_t;
  localparam logic [6:0] ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                     7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic       clk = 0, rst = 1;
  logic [7:0] data_in = 0;
  logic [7:0] seg_n;
  logic [5:0] an_n;
  logic       busy;
  int         checks = 0, errors = 0;
  exp_t       sb[$];
  logic [7:0] seen [6];

  shift_disp_driver #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .seg_n(seg_n), .an_n(an_n), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input int n);
    return {1'b1, ~ON[n]};
  endfunction

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] exp_digit(input int v, input int d);
    int h, t;
    h = v / 100;
    t = (v / 10) % 10;
    case (d)
      0: return glyph(v % 16);
      1: return glyph(v / 16);
      3: return glyph(v % 10);
      4: return (h == 0 && t == 0) ? 8'hFF : glyph(t);
      5: return h == 0 ? 8'hFF : glyph(h);
      default: return 8'hFF;
    endcase
  endfunction

  task automatic drive(input logic [7:0] v, input bit push);
    exp_t e;
    data_in = v;
    e.bin = v;
    e.bcd = ref_bcd(int'(v));
    if (push) sb.push_back(e);
  endtask

  task automatic conv_done(output bit ok, output int hi, output exp_t e);
    ok = 0;
    hi = 0;
    e = '0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (busy) hi++;
      else if (hi > 0) ok = 1;
    end
    if (ok && sb.size() > 0) e = sb.pop_front();
    else ok = 0;
  endtask

  task automatic capture(output int bad);
    bad = 0;
    for (int d = 0; d < 6; d++) seen[d] = 8'h00;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (!$onehot(~an_n) || seg_n[7] !== 1'b1) bad++;
      for (int d = 0; d < 6; d++) if (an_n[d] === 1'b0) seen[d] = seg_n;
    end
  endtask

  task automatic test_reset;
    int dig;
    rst = 1;
    data_in = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, an_n, seg_n} !== {1'b0, 6'b111110, 8'hFF}) begin
      errors++;
      $display("FAIL reset_vals: busy=%b an_n=%b seg_n=%h want 0 111110 ff", busy, an_n, seg_n);
    end
    rst = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      dig = ((k - 1) / 4) % 6;
      checks++;
      if (an_n !== ~(6'b1 << dig) || seg_n !== exp_digit(0, dig) || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_scan k=%0d: an_n=%b seg_n=%h busy=%b want %b %h 0",
                 k, an_n, seg_n, busy, ~(6'b1 << dig), exp_digit(0, dig));
      end
    end
  endtask

  task automatic test_value(input string name, input logic [7:0] v);
    bit ok;
    int hi, bad;
    exp_t e;
    drive(v, 1);
    conv_done(ok, hi, e);
    checks++;
    if (!ok || hi != 9) begin
      errors++;
      $display("FAIL %s busy_len: completed=%0d cycles=%0d want 1 9", name, ok, hi);
    end
    checks++;
    if (dut.disp_bin !== e.bin || dut.disp_bcd !== e.bcd) begin
      errors++;
      $display("FAIL %s disp: bin=%h bcd=%h want %h %h", name, dut.disp_bin, dut.disp_bcd, e.bin, e.bcd);
    end
    capture(bad);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s scan_form: bad cycles=%0d want 0", name, bad);
    end
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (seen[d] !== exp_digit(int'(v), d)) begin
        errors++;
        $display("FAIL %s digit%0d: seg_n=%h want %h", name, d, seen[d], exp_digit(int'(v), d));
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int hi, bad;
    exp_t e;
    drive(8'h10, 1);
    repeat (3) @(negedge clk);
    drive(8'hA5, 1);
    conv_done(ok, hi, e);
    checks++;
    if (!ok || dut.disp_bcd !== e.bcd || e.bcd !== 12'h016) begin
      errors++;
      $display("FAIL b2b_first: done=%0d bcd=%h want 016", ok, dut.disp_bcd);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: busy=%b want 1 one cycle after drop", busy);
    end
    conv_done(ok, hi, e);
    checks++;
    if (!ok || dut.disp_bcd !== e.bcd || dut.disp_bin !== e.bin) begin
      errors++;
      $display("FAIL b2b_second: done=%0d bin=%h bcd=%h want %h %h", ok, dut.disp_bin, dut.disp_bcd, e.bin, e.bcd);
    end
    capture(bad);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (seen[d] !== exp_digit(8'hA5, d)) begin
        errors++;
        $display("FAIL b2b digit%0d: seg_n=%h want %h", d, seen[d], exp_digit(8'hA5, d));
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int hi, bad;
    exp_t e;
    drive(8'hC8, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_start: busy=%b want 1", busy);
    end
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if ({busy, an_n, seg_n} !== {1'b0, 6'b111110, 8'hFF} || dut.disp_bin !== 8'h00 || dut.disp_bcd !== 12'h000) begin
      errors++;
      $display("FAIL rmid_reset: busy=%b an_n=%b seg_n=%h bin=%h bcd=%h want 0 111110 ff 00 000",
               busy, an_n, seg_n, dut.disp_bin, dut.disp_bcd);
    end
    rst = 0;
    drive(8'hC8, 1);
    conv_done(ok, hi, e);
    checks++;
    if (!ok || dut.disp_bcd !== e.bcd || e.bcd !== 12'h200) begin
      errors++;
      $display("FAIL rmid_restart: done=%0d bcd=%h want 200", ok, dut.disp_bcd);
    end
    capture(bad);
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (seen[d] !== exp_digit(8'hC8, d)) begin
        errors++;
        $display("FAIL rmid digit%0d: seg_n=%h want %h", d, seen[d], exp_digit(8'hC8, d));
      end
    end
  endtask

  task automatic test_sweep;
    for (int v = 0; v < 256; v++) test_value($sformatf("sweep_%0d", v), 8'(v));
  endtask

  initial begin
    test_reset;
    test_value("ff", 8'hFF);
    test_value("x07", 8'h07);
    test_value("x64", 8'h64);
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_disp_driver.md
# shift_disp_driver

Display stage directly downstream of the LED shift register. It consumes the register's 8-bit output and shows it on a six-digit, time-multiplexed, active-low seven-segment display. Digits 1..0 show the value in hex, digit 2 is blank, and digits 5..3 show it in unsigned decimal (0–255). Decimal conversion is a sequential double-dabble FSM that runs whenever the input value changes.

## Interface
- SCAN_DIV, default 50000: clk cycles each digit stays enabled; legal range ≥2.
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  value from the shift register, sampled every cycle.
- seg_n  output  8  segments, active-low; bit0=a … bit6=g, bit7=dp (dp always 1 = off).
- an_n  output  6  digit enables, active-low, exactly one bit low at all times after reset.
- busy  output  1  high while a conversion is in progress.

## Operation
- Registers:
  - last_val[7:0]: value most recently accepted.
  - sh[7:0]: shift source.
  - bcd[11:0]: work register.
  - bit_cnt[2:0]: iteration counter.
  - disp_bin[7:0], disp_bcd[11:0]: shown value.
  - scan_cnt, dig_idx[2:0] (0..5).
- FSM states IDLE, CONV, LOAD.
  - IDLE: if data_in != last_val, then sh←data_in, last_val←data_in, bcd←0, bit_cnt←0, go to CONV. Otherwise stay.
  - CONV: in one cycle, add 3 to each BCD nibble ≥5, then shift {bcd,sh} left by 1. bit_cnt increments. After the 8th shift (bit_cnt was 7), go to LOAD.
  - LOAD: disp_bin←last_val, disp_bcd←bcd, go to IDLE.
- busy = (state != IDLE).
- data_in changes during CONV/LOAD are not sampled. On return to IDLE the new input is compared with last_val; any difference starts a fresh conversion. Intermediate values may be skipped, but the final value always converges.
- Hex and decimal digits update together in LOAD and are never mutually inconsistent.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - On terminal count, scan_cnt←0 and dig_idx advances 0→1→…→5→0.
- Digit content:
  - 0 = disp_bin[3:0] hex.
  - 1 = disp_bin[7:4] hex.
  - 2 = blank.
  - 3 = ones.
  - 4 = tens, blanked if tens==0 and hundreds==0.
  - 5 = hundreds, blanked if 0.
- Hex glyphs 0–F use standard patterns with lowercase b, d. Blank = 8'hFF.

## Timing
- Reset values:
  - State IDLE, last_val=0, disp_bin=0, disp_bcd=0, scan_cnt=0, dig_idx=0.
  - seg_n=8'hFF, an_n=6'b111110, busy=0.
- seg_n and an_n are registered, one cycle behind dig_idx/display registers.
- Conversion latency:
  - data_in changes before edge t (sampled in IDLE at edge t).
  - busy rises after edge t.
  - 8 CONV cycles, then LOAD.
  - disp_* valid after edge t+9, busy low after edge t+9.
  - Visible on seg_n at the next registered digit output.
- Reset mid-conversion aborts: the display returns to showing 0 and the next cycle compares data_in against 0.
- Digit wrap from 5 to 0 has no gap cycle. The enable period per digit is exactly SCAN_DIV cycles.
- No operand exceeds 12 bits. Nibble adjust is 4-bit add, never overflowing since the input is at most 8'hFF.

## Structure
- Shared package shift_disp_pkg:
  - State enum {IDLE, CONV, LOAD}.
  - SEG_BLANK = 8'hFF.
  - Glyph constants SEG_0..SEG_F.
  - NUM_DIGITS = 6.
- Sub-module seg7_decode: combinational.
  - Inputs nibble[3:0] and blank.
  - Output seg_n[7:0].
  - Instantiated once on the muxed digit.
- FSM, double-dabble datapath and scan counter live in the top module.

## Test plan
- Reset, data_in=0 → busy never rises; with SCAN_DIV=4, an_n cycles 111110, 111101, …, 011111 every 4 cycles. Digit 0 and digit 1 show SEG_0, digit 3 shows SEG_0, digits 2, 4 and 5 show 8'hFF.
- data_in=8'hFF → busy high for exactly 9 cycles. disp_bcd=12'h255, and digits 1/0 show F/F, digits 5/4/3 show 2/5/5.
- data_in=8'h07 → hex 0/7, decimal digits 5 and 4 blank, digit 3 shows 7. data_in=8'h64 → decimal 100 with tens digit shown as 0 (not blanked).
- data_in 8'h10 then 8'hA5 three cycles later (during CONV) → first LOAD gives disp_bcd=12'h016. busy drops for one cycle, then a second conversion ends with disp_bcd=12'h165, disp_bin=8'hA5.
- rst asserted at the 4th CONV cycle of data_in=8'hC8 → all outputs at reset values. After release, conversion restarts and ends with disp_bcd=12'h200.
- Exhaustive sweep 0..255, each value held until busy falls → disp_bcd matches reference BCD for every value.
